// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Frame format: SOF, LEN (1..MAX_LEN), payload, 8-bit additive checksum.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_READY
   } state_e;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;
   localparam int         MAX_LEN_UB  = 16;

   function automatic logic len_ok(input logic [7:0] len, input int max_len);
      return (len != 8'd0) && (len <= 8'(max_len));
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// 16x8 payload register file: one synchronous write port,
// one asynchronous read port (show-ahead read data).
module uart_frame_buf (
   input  logic       clk,
   input  logic       we,
   input  logic [3:0] waddr,
   input  logic [7:0] wdata,
   input  logic [3:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem_q [16];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Assembles SOF/LEN/payload/checksum frames from a UART byte stream,
// holds a checked frame for reading and flags framing errors.
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_CLKS = 208320,
   parameter logic [7:0] SOF          = SOF_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       frame_ready,
   output logic [4:0] frame_len,
   output logic [7:0] rd_data,
   input  logic       rd_en,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_ovr
);

   localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   state_e        state_q, state_d;
   logic [4:0]    len_q, len_d;
   logic [7:0]    chk_q, chk_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    rd_ptr_q, rd_ptr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_chk_q, err_chk_d;
   logic          err_len_q, err_len_d;
   logic          err_tmo_q, err_tmo_d;
   logic          err_ovr_q, err_ovr_d;
   logic          buf_we;
   logic          counting;
   logic [7:0]    buf_rdata;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      chk_d     = chk_q;
      idx_d     = idx_q;
      rd_ptr_d  = rd_ptr_q;
      tmo_d     = tmo_q;
      err_chk_d = 1'b0;
      err_len_d = 1'b0;
      err_tmo_d = 1'b0;
      err_ovr_d = 1'b0;
      buf_we    = 1'b0;
      counting  = (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                  (state_q == S_CHK);

      if (rx_done)       tmo_d = '0;
      else if (counting) tmo_d = tmo_q + TW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (rx_done && rx_data == SOF) begin
               state_d = S_LEN;
               tmo_d   = '0;
            end
         end
         S_LEN: begin
            if (rx_done) begin
               if (len_ok(rx_data, MAX_LEN)) begin
                  len_d   = rx_data[4:0];
                  chk_d   = rx_data;
                  idx_d   = 4'd0;
                  state_d = S_PAYLOAD;
               end else begin
                  err_len_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_done) begin
               buf_we = 1'b1;
               chk_d  = chk_q + rx_data;
               idx_d  = idx_q + 4'd1;
               if ({1'b0, idx_q} == len_q - 5'd1) state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_done) begin
               if (rx_data == chk_q) begin
                  state_d  = S_READY;
                  rd_ptr_d = 4'd0;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end
         end
         S_READY: begin
            // Buffer is frozen here; incoming bytes are dropped.
            if (rx_done) err_ovr_d = 1'b1;
            if (rd_en) begin
               if ({1'b0, rd_ptr_q} == len_q - 5'd1) state_d = S_IDLE;
               else rd_ptr_d = rd_ptr_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (counting && !rx_done && tmo_q == TMO_LAST) begin
         err_tmo_d = 1'b1;
         state_d   = S_IDLE;
         tmo_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         chk_q     <= '0;
         idx_q     <= '0;
         rd_ptr_q  <= '0;
         tmo_q     <= '0;
         err_chk_q <= 1'b0;
         err_len_q <= 1'b0;
         err_tmo_q <= 1'b0;
         err_ovr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         chk_q     <= chk_d;
         idx_q     <= idx_d;
         rd_ptr_q  <= rd_ptr_d;
         tmo_q     <= tmo_d;
         err_chk_q <= err_chk_d;
         err_len_q <= err_len_d;
         err_tmo_q <= err_tmo_d;
         err_ovr_q <= err_ovr_d;
      end
   end

   uart_frame_buf u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (idx_q),
      .wdata (rx_data),
      .raddr (rd_ptr_q),
      .rdata (buf_rdata)
   );

   assign frame_ready = (state_q == S_READY);
   assign frame_len   = frame_ready ? len_q : 5'd0;
   assign rd_data     = frame_ready ? buf_rdata : 8'd0;
   assign err_chk     = err_chk_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_tmo_q;
   assign err_ovr     = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a queue-based frame model
// checked every cycle plus literal expectations for key scenarios.
module tb_uart_rx_frame_ctrl;

   localparam int         MAX_LEN = 16;
   localparam int         TMO     = 20;
   localparam logic [7:0] SOFB    = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rd_en;
   logic       frame_ready;
   logic [4:0] frame_len;
   logic [7:0] rd_data;
   logic       err_chk, err_len, err_timeout, err_ovr;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx_frame_ctrl #(
      .MAX_LEN      (MAX_LEN),
      .TIMEOUT_CLKS (TMO),
      .SOF          (SOFB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_done     (rx_done),
      .frame_ready (frame_ready),
      .frame_len   (frame_len),
      .rd_data     (rd_data),
      .rd_en       (rd_en),
      .err_chk     (err_chk),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .err_ovr     (err_ovr)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act,
                               input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Behavioural model: bytes after SOF are collected into a queue and
   // judged once the queue holds length + payload + checksum.
   bit         coll = 0;
   logic [7:0] cur[$];
   logic [7:0] held[$];
   int         held_len = 0;
   int         quiet = 0;
   bit         m_chk, m_len, m_tmo, m_ovr;
   bit         started = 0;

   always @(posedge clk) begin
      int sum;
      m_chk = 0; m_len = 0; m_tmo = 0; m_ovr = 0;
      if (rst) begin
         coll = 0; cur.delete(); held.delete(); quiet = 0;
      end else if (held.size() != 0) begin
         if (rx_done) m_ovr = 1;
         if (rd_en) void'(held.pop_front());
      end else if (coll) begin
         if (rx_done) begin
            quiet = 0;
            cur.push_back(rx_data);
            if (cur.size() == 1) begin
               if (rx_data == 0 || int'(rx_data) > MAX_LEN) begin
                  m_len = 1; coll = 0;
               end
            end else if (cur.size() == int'(cur[0]) + 2) begin
               sum = 0;
               for (int i = 0; i < cur.size() - 1; i++) sum += int'(cur[i]);
               if ((sum % 256) == int'(rx_data)) begin
                  held_len = int'(cur[0]);
                  for (int i = 1; i < cur.size() - 1; i++) held.push_back(cur[i]);
               end else m_chk = 1;
               coll = 0;
            end
         end else begin
            quiet++;
            if (quiet == TMO) begin m_tmo = 1; coll = 0; end
         end
      end else if (rx_done && rx_data == SOFB) begin
         coll = 1; cur.delete(); quiet = 0;
      end
   end

   int cnt_tmo = 0;
   int cnt_err = 0;

   always @(negedge clk) begin
      if (started) begin
         chk("model_ready", frame_ready, held.size() != 0);
         if (held.size() != 0) begin
            chk("model_len", frame_len, held_len);
            chk("model_rd_data", rd_data, held[0]);
         end
         chk("model_err_chk", err_chk, m_chk);
         chk("model_err_len", err_len, m_len);
         chk("model_err_timeout", err_timeout, m_tmo);
         chk("model_err_ovr", err_ovr, m_ovr);
         if (err_timeout) cnt_tmo++;
         cnt_err += int'(err_chk) + int'(err_len) + int'(err_timeout) + int'(err_ovr);
      end
   end

   task automatic send(input logic [7:0] b);
      rx_data = b; rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic read1();
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   initial begin
      int t0, e0;
      rst = 1'b1; rx_done = 1'b0; rd_en = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", frame_ready, 1'b0);
      chk("rst_len", frame_len, 5'd0);
      chk("rst_rd_data", rd_data, 8'd0);
      chk("rst_errs", {err_chk, err_len, err_timeout, err_ovr}, 4'b0);
      started = 1;

      read1();
      send(8'h33);
      idle(1);

      send(SOFB); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
      chk("f1_ready", frame_ready, 1'b1);
      chk("f1_len", frame_len, 5'd3);
      chk("f1_b0", rd_data, 8'h11);
      read1();
      chk("f1_b1", rd_data, 8'h22);
      read1();
      chk("f1_b2", rd_data, 8'h33);
      read1();
      chk("f1_done", frame_ready, 1'b0);

      send(SOFB); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
      chk("bad_chk_pulse", err_chk, 1'b1);
      chk("bad_chk_ready", frame_ready, 1'b0);
      send(SOFB); send(8'h01); send(8'h7F); send(8'h80);
      chk("f2_ready", frame_ready, 1'b1);
      chk("f2_len", frame_len, 5'd1);
      chk("f2_b0", rd_data, 8'h7F);
      read1();
      chk("f2_done", frame_ready, 1'b0);

      send(SOFB); send(8'h00);
      chk("len0_pulse", err_len, 1'b1);
      send(SOFB); send(8'h11);
      chk("len17_pulse", err_len, 1'b1);
      send(SOFB); send(8'h01); send(8'h05); send(8'h06);
      chk("f3_ready", frame_ready, 1'b1);
      read1();

      t0 = cnt_tmo;
      send(SOFB); send(8'h04); send(8'h01);
      idle(TMO + 3);
      chk("tmo_one_pulse", cnt_tmo - t0, 1);
      chk("tmo_ready", frame_ready, 1'b0);

      t0 = cnt_tmo;
      send(SOFB); send(8'h04); send(8'h01);
      idle(TMO - 1);
      send(8'h02);
      chk("tmo_edge_none", err_timeout, 1'b0);
      send(8'h03); send(8'h04); send(8'h0E);
      chk("tmo_edge_ready", frame_ready, 1'b1);
      chk("tmo_edge_b0", rd_data, 8'h01);
      read1();
      chk("tmo_edge_b1", rd_data, 8'h02);
      read1(); read1(); read1();
      chk("tmo_edge_done", frame_ready, 1'b0);
      chk("tmo_edge_count", cnt_tmo - t0, 0);

      send(SOFB); send(8'h02); send(8'hAA); send(8'hBB); send(8'h67);
      chk("ovr_ready", frame_ready, 1'b1);
      send(SOFB);
      chk("ovr_pulse", err_ovr, 1'b1);
      chk("ovr_b0", rd_data, 8'hAA);
      read1();
      chk("ovr_b1", rd_data, 8'hBB);
      rd_en = 1'b1; rx_done = 1'b1; rx_data = SOFB;
      @(posedge clk); #1;
      rd_en = 1'b0; rx_done = 1'b0;
      chk("ovr_last_pulse", err_ovr, 1'b1);
      chk("ovr_last_ready", frame_ready, 1'b0);
      send(8'h01);
      idle(2);
      chk("ovr_dropped_sof", frame_ready, 1'b0);

      idle(2);
      e0 = cnt_err;
      send(SOFB); send(8'h03); send(8'h11);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_ready", frame_ready, 1'b0);
      idle(TMO + 3);
      chk("midrst_no_err", cnt_err - e0, 0);
      send(SOFB); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
      chk("f4_ready", frame_ready, 1'b1);
      chk("f4_len", frame_len, 5'd3);
      chk("f4_b0", rd_data, 8'h11);
      read1();
      chk("f4_b1", rd_data, 8'h22);
      read1();
      chk("f4_b2", rd_data, 8'h33);
      read1();
      chk("f4_done", frame_ready, 1'b0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
